sorting: RTL and testbench

- 32-point bit-reversal reorder buffer at the output of the 32-point radix-2 FFT pipeline.
- Accepts one complex sample per clock: 10-bit signed real, 8-bit signed imaginary.
- After a full frame is captured, emits that frame with sample index bit-reversed.
- Uses ping-pong storage so back-to-back frames stream without gaps.

---
 rtl/sorting.sv | 110 +++++++++++
 tb/tb_sorting.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sorting.sv
// rtl/sorting.sv - 32-point bit-reversal reorder buffer with ping-pong banks
module sorting #(
  parameter int WR = 10,
  parameter int WI = 8,
  parameter int N  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_sorting,
  input  logic signed [WR-1:0] out_r,
  input  logic signed [WI-1:0] out_i,
  output logic signed [WR-1:0] answer_r,
  output logic signed [WI-1:0] answer_i,
  output logic                 answer_valid
);

  localparam int W = WR + WI;

  typedef enum logic {IDLE, READ} state_t;

  logic [W-1:0] bank [2][N];
  logic [4:0]   wcnt;
  logic         wsel;
  logic [4:0]   rcnt;
  logic         rsel;
  logic         pend;
  logic         pend_sel;
  state_t       state;

  logic         frame_done;
  logic         have_req;
  logic         req_sel;
  logic [W-1:0] rd_word;

  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // frame_done sees wsel before its toggle, i.e. the bank just completed
  assign frame_done = start_sorting && (wcnt == 5'd31);
  assign have_req   = pend || frame_done;
  assign req_sel    = pend ? pend_sel : wsel;
  assign rd_word    = bank[rsel][bitrev5(rcnt)];

  always_ff @(posedge clk) begin
    if (!rst && start_sorting) begin
      bank[wsel][wcnt] <= {out_r, out_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      wsel <= 1'b0;
    end else if (start_sorting) begin
      wcnt <= wcnt + 5'd1;
      if (wcnt == 5'd31) begin
        wsel <= ~wsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rcnt         <= '0;
      rsel         <= 1'b0;
      pend         <= 1'b0;
      pend_sel     <= 1'b0;
      answer_r     <= '0;
      answer_i     <= '0;
      answer_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          answer_r     <= '0;
          answer_i     <= '0;
          answer_valid <= 1'b0;
          if (have_req) begin
            state <= READ;
            rsel  <= req_sel;
            rcnt  <= '0;
            // a pending request and a fresh one together keep the fresh one queued
            pend     <= pend && frame_done;
            pend_sel <= wsel;
          end
        end
        READ: begin
          {answer_r, answer_i} <= rd_word;
          answer_valid         <= 1'b1;
          rcnt                 <= rcnt + 5'd1;
          if (rcnt == 5'd31) begin
            if (have_req) begin
              rsel     <= req_sel;
              pend     <= pend && frame_done;
              pend_sel <= wsel;
            end else begin
              state <= IDLE;
            end
          end else if (frame_done) begin
            pend     <= 1'b1;
            pend_sel <= wsel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorting.sv
// tb/tb_sorting.sv - directed and random frames checked against a queue-based reorder model
module tb_sorting;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_sorting;
  logic signed [9:0] out_r;
  logic signed [7:0] out_i;
  logic signed [9:0] answer_r;
  logic signed [7:0] answer_i;
  logic              answer_valid;

  sorting #(.WR(10), .WI(8), .N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_sorting(start_sorting),
    .out_r        (out_r),
    .out_i        (out_i),
    .answer_r     (answer_r),
    .answer_i     (answer_i),
    .answer_valid (answer_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int order [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                     1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  logic [17:0] frame_buf [32];
  int          fcnt = 0;
  logic [17:0] exp_q [$];
  logic        exp_v;
  logic [9:0]  exp_r;
  logic [7:0]  exp_i;

  // Model: a completed frame queues its 32 samples in output order; one pops per edge.
  task automatic step(input logic r, input logic s, input logic [9:0] dr, input logic [7:0] di);
    logic [17:0] w;
    rst           = r;
    start_sorting = s;
    out_r         = dr;
    out_i         = di;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      fcnt  = 0;
      exp_v = 1'b0;
      exp_r = '0;
      exp_i = '0;
    end else begin
      if (exp_q.size() > 0) begin
        w     = exp_q.pop_front();
        exp_v = 1'b1;
        exp_r = w[17:8];
        exp_i = w[7:0];
      end else begin
        exp_v = 1'b0;
        exp_r = '0;
        exp_i = '0;
      end
      if (s) begin
        frame_buf[fcnt] = {dr, di};
        fcnt++;
        if (fcnt == 32) begin
          for (int k = 0; k < 32; k++) exp_q.push_back(frame_buf[order[k]]);
          fcnt = 0;
        end
      end
    end
    #1;
    vectors++;
    assert (answer_valid === exp_v) else begin
      miscompares++;
      $error("FAIL answer_valid: got %0b want %0b at %0t", answer_valid, exp_v, $time);
    end
    vectors++;
    assert (answer_r === exp_r) else begin
      miscompares++;
      $error("FAIL answer_r: got %0d want %0d at %0t", answer_r, $signed(exp_r), $time);
    end
    vectors++;
    assert (answer_i === exp_i) else begin
      miscompares++;
      $error("FAIL answer_i: got %0d want %0d at %0t", answer_i, $signed(exp_i), $time);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 10'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    start_sorting = 1'b0;
    out_r = '0;
    out_i = '0;

    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);

    // ramp
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 10'(k), 8'(k));
    idle(40);

    // signed pass-through
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 10'(-512 + k), 8'(-128 + k));
    idle(40);

    // three back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 10'(32 * f + k), 8'(32 * f + k));
    idle(40);

    // five-cycle stall after sample 10
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b1, 10'(k), 8'(k));
      if (k == 10) for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 10'($urandom), 8'($urandom));
    end
    idle(40);

    // reset at sample 20 of frame 1 while frame 0 is being read
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 10'(100 + k), 8'(k));
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 10'(200 + k), 8'(50 + k));
    step(1'b1, 1'b1, 10'd220, 8'd70);
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 10'(k), 8'(k));
    idle(40);

    // long idle
    idle(100);

    // random frames with random stalls
    for (int f = 0; f < 6; f++) begin
      int k;
      k = 0;
      while (k < 32) begin
        if ($urandom_range(3) == 0) begin
          step(1'b0, 1'b0, 10'($urandom), 8'($urandom));
        end else begin
          step(1'b0, 1'b1, 10'($urandom), 8'($urandom));
          k++;
        end
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
